result_axis_serializer: RTL

//  Downstream of the systolic array AXI wrapper. Accepts one full result matrix per

---
 rtl/result_axis_serializer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/result_axis_serializer.sv
// Serializes one 144-bit result matrix per handshake into 32-bit AXI-Stream beats for the DMA S2MM channel.
// Optional feature macro: RESULT_TKEEP_EN adds the m_axis_keep byte-strobe output.
module result_axis_serializer #(
    parameter int ELEM_W         = 16,
    parameter int N_ELEMS        = 9,
    parameter int ELEMS_PER_BEAT = 2
) (
    input  logic                               axi_clk,
    input  logic                               axi_rst_n,
    input  logic                               s_axis_valid,
    input  logic [ELEM_W*N_ELEMS-1:0]          s_axis_data,
    output logic                               s_axis_ready,
    output logic                               m_axis_valid,
    output logic [ELEM_W*ELEMS_PER_BEAT-1:0]   m_axis_data,
    output logic                               m_axis_last,
    input  logic                               m_axis_ready
`ifdef RESULT_TKEEP_EN
    ,
    output logic [ELEM_W*ELEMS_PER_BEAT/8-1:0] m_axis_keep
`endif
);

    localparam int IN_W  = ELEM_W * N_ELEMS;
    localparam int OUT_W = ELEM_W * ELEMS_PER_BEAT;
    localparam int BEATS = (N_ELEMS + ELEMS_PER_BEAT - 1) / ELEMS_PER_BEAT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        next_cnt;
    logic [IN_W-1:0]         hold_q;
    logic                    load;
    logic                    last_beat;
    logic [BEATS*OUT_W-1:0]  padded;

    assign last_beat = (state == SEND) && (beat_cnt == LAST_CNT);

    // Ready is gated by reset so the upstream never hands over a matrix that would be dropped.
    assign s_axis_ready = axi_rst_n & ((state == IDLE) | (last_beat & m_axis_ready));

    assign m_axis_valid = (state == SEND);
    assign m_axis_last  = last_beat;

    always_comb begin
        next_state = state;
        next_cnt   = beat_cnt;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_valid) begin
                    load       = 1'b1;
                    next_cnt   = '0;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (m_axis_ready) begin
                    if (beat_cnt != LAST_CNT) begin
                        next_cnt = beat_cnt + 1'b1;
                    end else if (s_axis_valid) begin
                        load     = 1'b1;
                        next_cnt = '0;
                    end else begin
                        next_cnt   = '0;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            hold_q   <= '0;
        end else begin
            state    <= next_state;
            beat_cnt <= next_cnt;
            if (load) begin
                hold_q <= s_axis_data;
            end
        end
    end

    // Zero-extending the matrix to a whole number of beats makes the pad slots of the final beat read as zero.
    always_comb begin
        padded           = '0;
        padded[IN_W-1:0] = hold_q;
    end

    always_comb begin
        m_axis_data = '0;
        if (state == SEND) begin
            m_axis_data = padded[int'(beat_cnt)*OUT_W +: OUT_W];
        end
    end

`ifdef RESULT_TKEEP_EN
    localparam int BYTES_PER_ELEM = ELEM_W / 8;

    always_comb begin
        m_axis_keep = '0;
        if (state == SEND) begin
            for (int j = 0; j < ELEMS_PER_BEAT; j++) begin
                if (int'(beat_cnt) * ELEMS_PER_BEAT + j < N_ELEMS) begin
                    m_axis_keep[j*BYTES_PER_ELEM +: BYTES_PER_ELEM] = '1;
                end
            end
        end
    end
`endif

endmodule
